// File: rtl/colour_scan_sequencer.sv
`timescale 1ns/1ps
// colour_scan_sequencer: one RGB scan of a TCS3200-style sensor. Selects each
// filter, lets it settle, counts synchronised freq edges over a gate window,
// then classifies the dominant colour and drives the status LED.
// Build option: COLOUR_CONTINUOUS_EN -> rescan forever after reset release.
//
// state   | meaning
// IDLE    | sensor powered down (s=0000), waiting for start
// SETTLE  | filter selected, edges ignored while the sensor output settles
// MEASURE | counting edge pulses for GATE_CYCLES clocks
// DECIDE  | one cycle: classify shadows, publish results, pulse done
module colour_scan_sequencer #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int GATE_CYCLES   = 100000,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             freq,
    output logic [3:0]       s,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [1:0]       colour,
    output logic [2:0]       led
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DECIDE} state_t;
    typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_t;

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t             state_q, state_d;
    ch_t                ch_q, ch_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]   red_sh_q, red_sh_d, grn_sh_q, grn_sh_d, blu_sh_q, blu_sh_d;
    logic [CNT_W-1:0]   red_out_q, red_out_d, grn_out_q, grn_out_d, blu_out_q, blu_out_d;
    logic [1:0]         colour_q, colour_d;
    logic [2:0]         led_q, led_d;
    logic               freq_s1_q, freq_s1_d, freq_s2_q, freq_s2_d, freq_dly_q, freq_dly_d;
    logic               edge_pulse, launch, in_decide;
    logic [CNT_W-1:0]   dec_max;
    logic [1:0]         dec_colour;
    logic [2:0]         dec_led;

    // Synchroniser chain for the asynchronous sensor output and its rising-edge pulse
    always_comb begin
        freq_s1_d  = freq;
        freq_s2_d  = freq_s1_q;
        freq_dly_d = freq_s2_q;
        edge_pulse = freq_s2_q & ~freq_dly_q;
    end

`ifdef COLOUR_CONTINUOUS_EN
    assign launch = 1'b1;
`else
    assign launch = start;
`endif

    // Saturating increment of the working counter
    always_comb begin
        cnt_inc = cnt_q;
        if (edge_pulse && (cnt_q != CNT_MAX)) cnt_inc = cnt_q + 1'b1;
    end

    // Classification: max of shadows, ties resolved red > green > blue
    always_comb begin
        dec_max    = red_sh_q;
        dec_colour = 2'b01;
        if ((red_sh_q >= grn_sh_q) && (red_sh_q >= blu_sh_q)) begin
            dec_max    = red_sh_q;
            dec_colour = 2'b01;
        end else if (grn_sh_q >= blu_sh_q) begin
            dec_max    = grn_sh_q;
            dec_colour = 2'b10;
        end else begin
            dec_max    = blu_sh_q;
            dec_colour = 2'b11;
        end
        if (int'(dec_max) < MIN_COUNT) dec_colour = 2'b00;
        case (dec_colour)
            2'b01:   dec_led = 3'b100;
            2'b10:   dec_led = 3'b010;
            2'b11:   dec_led = 3'b001;
            default: dec_led = 3'b000;
        endcase
    end

    // Next-state, timer, counter and result-register logic
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        red_sh_d  = red_sh_q;
        grn_sh_d  = grn_sh_q;
        blu_sh_d  = blu_sh_q;
        red_out_d = red_out_q;
        grn_out_d = grn_out_q;
        blu_out_d = blu_out_q;
        colour_d  = colour_q;
        led_d     = led_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = SETTLE;
                    ch_d    = CH_R;
                    timer_d = SETTLE_LOAD;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = MEASURE;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            MEASURE: begin
                cnt_d = cnt_inc;
                if (timer_q == '0) begin
                    case (ch_q)
                        CH_R:    red_sh_d = cnt_inc;
                        CH_G:    grn_sh_d = cnt_inc;
                        default: blu_sh_d = cnt_inc;
                    endcase
                    if (ch_q == CH_B) begin
                        state_d = DECIDE;
                    end else begin
                        ch_d    = (ch_q == CH_R) ? CH_G : CH_B;
                        cnt_d   = '0;
                        timer_d = SETTLE_LOAD;
                        state_d = SETTLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DECIDE: begin
                red_out_d = red_sh_q;
                grn_out_d = grn_sh_q;
                blu_out_d = blu_sh_q;
                colour_d  = dec_colour;
                led_d     = dec_led;
`ifdef COLOUR_CONTINUOUS_EN
                state_d   = SETTLE;
                ch_d      = CH_R;
                timer_d   = SETTLE_LOAD;
                cnt_d     = '0;
`else
                state_d   = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: results show the fresh classification during DECIDE, then hold
    always_comb begin
        in_decide = (state_q == DECIDE);
        busy      = (state_q != IDLE);
        done      = in_decide;
        red_cnt   = in_decide ? red_sh_q : red_out_q;
        green_cnt = in_decide ? grn_sh_q : grn_out_q;
        blue_cnt  = in_decide ? blu_sh_q : blu_out_q;
        colour    = in_decide ? dec_colour : colour_q;
        led       = in_decide ? dec_led : led_q;
        case (ch_q)
            CH_R:    s = 4'b0001;
            CH_G:    s = 4'b1101;
            default: s = 4'b1001;
        endcase
        if (state_q == IDLE) s = 4'b0000;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= CH_R;
            timer_q    <= '0;
            cnt_q      <= '0;
            red_sh_q   <= '0;
            grn_sh_q   <= '0;
            blu_sh_q   <= '0;
            red_out_q  <= '0;
            grn_out_q  <= '0;
            blu_out_q  <= '0;
            colour_q   <= 2'b00;
            led_q      <= 3'b000;
            freq_s1_q  <= 1'b0;
            freq_s2_q  <= 1'b0;
            freq_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            red_sh_q   <= red_sh_d;
            grn_sh_q   <= grn_sh_d;
            blu_sh_q   <= blu_sh_d;
            red_out_q  <= red_out_d;
            grn_out_q  <= grn_out_d;
            blu_out_q  <= blu_out_d;
            colour_q   <= colour_d;
            led_q      <= led_d;
            freq_s1_q  <= freq_s1_d;
            freq_s2_q  <= freq_s2_d;
            freq_dly_q <= freq_dly_d;
        end
    end

endmodule

// File: tb/tb_colour_scan_sequencer.sv
`timescale 1ns/1ps
// Bench for colour_scan_sequencer: a main instance (CNT_W=16) and a narrow
// instance (CNT_W=4) run in lockstep from the same pins. Expected counts come
// from the recorded freq rise times and the scan's window arithmetic.
module tb_colour_scan_sequencer;

    localparam int S    = 4;
    localparam int G    = 100;
    localparam int SG   = S + G;
    localparam int W    = 16;
    localparam int W2   = 4;
    localparam int MINC = 2;

    logic clk = 1'b0;
    logic rst, start, freq;
    logic [3:0]    s, s2;
    logic          busy, busy2, done, done2;
    logic [W-1:0]  red_cnt, green_cnt, blue_cnt;
    logic [W2-1:0] red2, green2, blue2;
    logic [1:0]    colour, colour2;
    logic [2:0]    led, led2;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int per_r = 0, per_g = 0, per_b = 0;
    int ph;
    int gen_per;
    logic gen_nf;
    int rises[$];
    logic [3:0] sel_tab [3];

    colour_scan_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(W), .MIN_COUNT(MINC)) dut (
        .clk(clk), .rst(rst), .start(start), .freq(freq), .s(s), .busy(busy), .done(done),
        .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt), .colour(colour), .led(led));

    colour_scan_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(W2), .MIN_COUNT(MINC)) dut_narrow (
        .clk(clk), .rst(rst), .start(start), .freq(freq), .s(s2), .busy(busy2), .done(done2),
        .red_cnt(red2), .green_cnt(green2), .blue_cnt(blue2), .colour(colour2), .led(led2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Sensor model: square wave whose period depends on the selected filter.
    always @(negedge clk) begin
        case (s)
            4'b0001: gen_per = per_r;
            4'b1101: gen_per = per_g;
            4'b1001: gen_per = per_b;
            default: gen_per = 0;
        endcase
        if (gen_per == 0) gen_nf = 1'b0;
        else              gen_nf = ((ph % gen_per) < (gen_per / 2));
        ph = ph + 1;
        if (gen_nf && !freq) rises.push_back(cyc);
        freq = gen_nf;
    end

    // A rise driven after posedge n becomes a pulse in the period after posedge n+2;
    // channel c counts in the periods after posedges e+c*SG+S .. e+c*SG+S+G-1.
    function automatic int model_count(int e, int c, int w);
        int n = 0;
        int lo = e + c * SG + S;
        int hi = lo + G - 1;
        foreach (rises[i])
            if ((rises[i] + 2 >= lo) && (rises[i] + 2 <= hi)) n++;
        if (n > (1 << w) - 1) n = (1 << w) - 1;
        return n;
    endfunction

    function automatic logic [1:0] model_colour(int r, int g, int b);
        int m;
        logic [1:0] c;
        if (r >= g && r >= b) begin m = r; c = 2'b01; end
        else if (g >= b)      begin m = g; c = 2'b10; end
        else                  begin m = b; c = 2'b11; end
        if (m < MINC) c = 2'b00;
        return c;
    endfunction

    function automatic logic [2:0] model_led(logic [1:0] c);
        case (c)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s !== 4'b0000 || s2 !== 4'b0000) begin errors++; $display("FAIL reset_s got=%b/%b exp=0000", s, s2); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done got=%b%b%b%b exp=0000", busy, done, busy2, done2);
        end
        checks++;
        if (red_cnt !== 16'd0 || green_cnt !== 16'd0 || blue_cnt !== 16'd0 || colour !== 2'b00 || led !== 3'b000) begin
            errors++; $display("FAIL reset_results got=%0d/%0d/%0d c=%b l=%b exp=0", red_cnt, green_cnt, blue_cnt, colour, led);
        end
`ifndef COLOUR_CONTINUOUS_EN
        per_r = 10; per_g = 10; per_b = 10;
        rst = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            checks++;
            if (s !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || colour !== 2'b00 || led !== 3'b000 ||
                red_cnt !== 16'd0 || s2 !== 4'b0000 || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got s=%b busy=%b done=%b colour=%b led=%b red=%0d exp all zero",
                         cyc, s, busy, done, colour, led, red_cnt);
                break;
            end
        end
`endif
    endtask

    task test_scan(input string name, input int pr, input int pg, input int pb, input int start_off);
        int e, done_at, er, eg, eb, er2, eg2, eb2;
        bit got;
        logic [1:0] ec, ec2;
        per_r = pr; per_g = pg; per_b = pb;
        @(negedge clk);
        rises.delete();
        start = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        done_at = -1;
        checks++;
        if (busy !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL %s busy_rise got=%b/%b exp=1", name, busy, busy2); end
        for (int t = 0; t < 3 * SG + 20; t++) begin
            for (int c = 0; c < 3; c++) begin
                if (cyc == e + c * SG + 1 || cyc == e + c * SG + S + G / 2) begin
                    checks++;
                    if (s !== sel_tab[c]) begin errors++; $display("FAIL %s select ch=%0d cyc=%0d got=%b exp=%b", name, c, cyc, s, sel_tab[c]); end
                end
            end
            if (done === 1'b1) begin got = 1'b1; done_at = cyc; break; end
            start = (start_off >= 0 && cyc == e + start_off);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!got || done_at != e + 3 * SG) begin
            errors++; $display("FAIL %s done_timing got=%0d exp=%0d", name, done_at - e, 3 * SG);
        end
        er  = model_count(e, 0, W);  eg  = model_count(e, 1, W);  eb  = model_count(e, 2, W);
        er2 = model_count(e, 0, W2); eg2 = model_count(e, 1, W2); eb2 = model_count(e, 2, W2);
        ec  = model_colour(er, eg, eb);
        ec2 = model_colour(er2, eg2, eb2);
        checks++;
        if (red_cnt !== 16'(er)) begin errors++; $display("FAIL %s red_cnt got=%0d exp=%0d", name, red_cnt, er); end
        checks++;
        if (green_cnt !== 16'(eg)) begin errors++; $display("FAIL %s green_cnt got=%0d exp=%0d", name, green_cnt, eg); end
        checks++;
        if (blue_cnt !== 16'(eb)) begin errors++; $display("FAIL %s blue_cnt got=%0d exp=%0d", name, blue_cnt, eb); end
        checks++;
        if (colour !== ec || led !== model_led(ec)) begin
            errors++; $display("FAIL %s colour got=%b led=%b exp=%b led=%b", name, colour, led, ec, model_led(ec));
        end
        checks++;
        if (done2 !== 1'b1 || red2 !== 4'(er2) || green2 !== 4'(eg2) || blue2 !== 4'(eb2)) begin
            errors++; $display("FAIL %s narrow_counts got=%b %0d/%0d/%0d exp=1 %0d/%0d/%0d", name, done2, red2, green2, blue2, er2, eg2, eb2);
        end
        checks++;
        if (colour2 !== ec2 || led2 !== model_led(ec2)) begin
            errors++; $display("FAIL %s narrow_colour got=%b led=%b exp=%b", name, colour2, led2, ec2);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s busy_fall got busy=%b done=%b exp=0 0", name, busy, done); end
        checks++;
        if (red_cnt !== 16'(er) || colour !== ec) begin
            errors++; $display("FAIL %s results_hold got=%0d c=%b exp=%0d c=%b", name, red_cnt, colour, er, ec);
        end
    endtask

    task test_red_dominant;
        test_scan("red_dominant", 10, 20, 40, -1);
    endtask

    task test_tie;
        test_scan("tie_gb", 0, 8, 8, -1);
    endtask

    task test_silent;
        test_scan("silent", 0, 0, 0, -1);
    endtask

    task test_saturation;
        test_scan("saturation", 4, 4, 4, -1);
        repeat (20) @(negedge clk);
        checks++;
        if (red2 !== 4'd15 || green2 !== 4'd15 || blue2 !== 4'd15) begin
            errors++; $display("FAIL sat_hold got=%0d/%0d/%0d exp=15/15/15", red2, green2, blue2);
        end
        checks++;
        if (red_cnt !== 16'd25 || green_cnt !== 16'd25 || blue_cnt !== 16'd25) begin
            errors++; $display("FAIL sat_wide got=%0d/%0d/%0d exp=25/25/25", red_cnt, green_cnt, blue_cnt);
        end
    endtask

    task test_start_ignored;
        bit relaunched;
        test_scan("start_in_measure_g", 10, 12, 14, SG + S + 20);
        relaunched = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (busy !== 1'b0) relaunched = 1'b1;
        end
        checks++;
        if (relaunched) begin errors++; $display("FAIL start_not_queued got busy=1 exp busy=0"); end
    endtask

    task test_random;
        int p [3];
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 3; c++) begin
                case ($urandom_range(0, 3))
                    0:       p[c] = 0;
                    1:       p[c] = 2 * $urandom_range(2, 10);
                    2:       p[c] = 2 * $urandom_range(10, 40);
                    default: p[c] = 2 * $urandom_range(90, 140);
                endcase
            end
            test_scan("random", p[0], p[1], p[2], -1);
        end
    endtask

    task test_abort;
        int e;
        test_scan("pre_abort", 6, 6, 6, -1);
        @(negedge clk);
        start = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 3 * SG && cyc < e + 2 * SG + 1; t++) @(negedge clk);
        checks++;
        if (s !== 4'b1001 || busy !== 1'b1) begin errors++; $display("FAIL abort_in_settle_b got s=%b busy=%b exp=1001 1", s, busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s !== 4'b0000 || busy !== 1'b0 || s2 !== 4'b0000 || busy2 !== 1'b0) begin
            errors++; $display("FAIL abort_state got s=%b busy=%b exp=0000 0", s, busy);
        end
        checks++;
        if (red_cnt !== 16'd0 || green_cnt !== 16'd0 || blue_cnt !== 16'd0 || colour !== 2'b00 || led !== 3'b000 ||
            red2 !== 4'd0 || colour2 !== 2'b00) begin
            errors++; $display("FAIL abort_results got=%0d/%0d/%0d c=%b l=%b exp=0", red_cnt, green_cnt, blue_cnt, colour, led);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s !== 4'b0000) begin errors++; $display("FAIL abort_idle got busy=%b s=%b exp=0 0000", busy, s); end
    endtask

    task test_continuous;
        int e, d1, d2, er;
        bit got, busy_low, s_zero;
        per_r = 10; per_g = 20; per_b = 40;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rises.delete();
        rst = 1'b0;
        e = cyc + 1;
        got = 1'b0; d1 = -1;
        for (int t = 0; t < 3 * SG + 20; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; d1 = cyc; break; end
        end
        checks++;
        if (!got || d1 != e + 3 * SG) begin errors++; $display("FAIL cont_first_done got=%0d exp=%0d", d1 - e, 3 * SG); end
        er = model_count(e, 0, W);
        checks++;
        if (red_cnt !== 16'(er) || colour !== model_colour(er, model_count(e, 1, W), model_count(e, 2, W))) begin
            errors++; $display("FAIL cont_first_result got=%0d c=%b exp=%0d", red_cnt, colour, er);
        end
        got = 1'b0; d2 = -1; busy_low = 1'b0; s_zero = 1'b0;
        for (int t = 0; t < 3 * SG + 20; t++) begin
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (busy !== 1'b1) busy_low = 1'b1;
            if (s === 4'b0000) s_zero = 1'b1;
            if (done === 1'b1) begin got = 1'b1; d2 = cyc; break; end
        end
        start = 1'b0;
        checks++;
        if (!got || d2 - d1 != 3 * SG + 1) begin errors++; $display("FAIL cont_spacing got=%0d exp=%0d", d2 - d1, 3 * SG + 1); end
        checks++;
        if (busy_low || s_zero) begin errors++; $display("FAIL cont_busy_s got busy_low=%b s_zero=%b exp=0 0", busy_low, s_zero); end
        er = model_count(d1 + 1, 2, W);
        checks++;
        if (blue_cnt !== 16'(er)) begin errors++; $display("FAIL cont_second_blue got=%0d exp=%0d", blue_cnt, er); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        freq = 1'b0;
        ph = $urandom_range(0, 1000);
        sel_tab[0] = 4'b0001;
        sel_tab[1] = 4'b1101;
        sel_tab[2] = 4'b1001;
        test_reset();
`ifdef COLOUR_CONTINUOUS_EN
        test_continuous();
`else
        test_red_dominant();
        test_tie();
        test_silent();
        test_saturation();
        test_start_ignored();
        test_random();
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/colour_scan_sequencer.md
# colour_scan_sequencer

Sequences one full RGB measurement on the TCS3200-style colour sensor front end. It drives the filter-select and frequency-scaling pins, counts sensor output edges over a fixed gate window for each of the red, green and blue filters, then classifies the dominant colour. It sits between the sensor pins and the bot's status LED and telemetry logic, and replaces ad-hoc select switching with one deterministic scan.

## Interface
- `SETTLE_CYCLES`, 1000: clocks held after each filter change before counting starts (≥1).
- `GATE_CYCLES`, 100000: clocks per counting window (≥1).
- `CNT_W`, 16: width of each channel edge counter.
- `MIN_COUNT`, 8: the winning count must be ≥ this value or the result is "none".
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request one scan; sampled only in IDLE.
- `freq` input, 1 bit: sensor square-wave output, asynchronous to `clk`.
- `s` output, 4 bits: {S3,S2,S1,S0} sensor select pins.
- `busy` output, 1 bit: high from scan acceptance until the `done` cycle, inclusive.
- `done` output, 1 bit: single-cycle pulse when results update.
- `red_cnt`, `green_cnt`, `blue_cnt` outputs, `CNT_W` bits each: last completed counts.
- `colour` output, 2 bits: 00 none, 01 red, 10 green, 11 blue.
- `led` output, 3 bits: one-hot in RGB order (100 red, 010 green, 001 blue, 000 none).

## Operation
- `freq` passes through a 2-flop synchroniser plus a delay flop. A rising-edge pulse is produced when the synchronised value goes 0→1.
- FSM states are IDLE, SETTLE, MEASURE and DECIDE. The channel index `ch` cycles R→G→B.
- In IDLE, `s` = 0000 (sensor powered down). `start`=1 moves to SETTLE with ch=R and the working counter cleared.
- Select values for the whole of SETTLE and MEASURE, with 20% scaling:
  - R = 0001
  - G = 1101
  - B = 1001
- In SETTLE, the FSM waits `SETTLE_CYCLES` clocks and ignores edges, then moves to MEASURE.
- In MEASURE, the FSM counts edge pulses for exactly `GATE_CYCLES` clocks. The count saturates at 2^CNT_W−1 and does not wrap.
- At the end of MEASURE:
  - The working count is stored into that channel's shadow register.
  - If ch≠B: advance ch, clear the working counter, go to SETTLE.
  - If ch=B: go to DECIDE.
- In DECIDE (one cycle), the FSM computes the maximum of the three shadows.
  - Tie priority is red > green > blue.
  - If the maximum is < `MIN_COUNT`, the result is none.
  - `red_cnt`/`green_cnt`/`blue_cnt`, `colour` and `led` load together and `done` pulses. The FSM then returns to IDLE.
- Outputs hold their values until the next DECIDE or reset. A scan that is cut short never updates them.
- `start` while busy is ignored and not queued.

## Timing
- Reset values: `s`=0000, `busy`=0, `done`=0, all counts 0, `colour`=00, `led`=000, FSM=IDLE, ch=R.
- Reset mid-scan aborts immediately to the reset state. It takes priority over every other event.
- `start` high in IDLE at edge k gives `busy`=1 from k+1.
- `done`=1 and the new results appear at cycle k+3·(SETTLE_CYCLES+GATE_CYCLES)+1. `busy` falls the following cycle.
- Edge-count latency is 3 clocks from a `freq` rising edge to the count increment. An edge is counted iff its pulse lands in a MEASURE cycle.
- Edge pulses can be produced at most every 2 clocks, so `freq` must stay below clk/2.

## Configuration
- `COLOUR_CONTINUOUS_EN` defined: after DECIDE the FSM goes straight to SETTLE(R) and rescans indefinitely.
  - `start` is ignored.
  - `busy` stays high after the first scan is launched by `start` or by reset release.
  - `done` pulses once per completed scan.
  - `s` never returns to 0000 except in reset.
- Not defined: single-shot behaviour exactly as in Operation.

## Test plan
- Reset then idle: with SETTLE=4, GATE=100 and no start, all outputs stay at reset values; `s`=0000 for 50 cycles.
- Red dominant: `freq` periods of 10/20/40 clk for R/G/B, MIN=2.
  - Expect ≈10/5/2 counts (±1).
  - Expect `colour`=01, `led`=100, and `done` exactly at k+313.
- Tie and threshold:
  - Equal G and B periods of 8 clk with R silent → `colour`=10.
  - All channels silent → `colour`=00, `led`=000, counts 0.
- Saturation: CNT_W=4, `freq` period 4 clk, GATE=100 → each count = 15 and holds without wrapping.
- Abort and ignore:
  - `start` pulsed during MEASURE(G) leaves the timing unchanged.
  - `rst` during SETTLE(B) returns `s`=0000 and `busy`=0 next cycle, with prior results cleared to 0.
- Continuous mode (`COLOUR_CONTINUOUS_EN`): two consecutive `done` pulses spaced exactly 3·(SETTLE+GATE)+1 cycles apart, and `start` has no effect.
